// File: rtl/register_file_scoreboard.sv
// DEPTH x BITS register file with two combinational read ports, one write port,
// optional zero register / write bypass, and a busy scoreboard for pending writebacks.

module register_file_scoreboard_rdport #(
    parameter  int DEPTH    = 32,
    parameter  int BITS     = 64,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic [AW-1:0]              addr,
    input  logic [DEPTH-1:0][BITS-1:0] regs,
    input  logic [DEPTH-1:0]           busy,
    input  logic                       fwd_en,
    input  logic [AW-1:0]              addressw,
    input  logic [BITS-1:0]            writeData,
    output logic [BITS-1:0]            rdata,
    output logic                       rbusy
);
    logic is_zero;
    logic fwd;

    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign fwd     = fwd_en && (addr == addressw);

    // Zero register dominates the bypass so r0 can never leak a dropped write.
    always_comb begin
        rdata = regs[addr];
        rbusy = busy[addr];
        if (fwd) begin
            rdata = writeData;
            rbusy = 1'b0;
        end
        if (is_zero) begin
            rdata = '0;
            rbusy = 1'b0;
        end
    end
endmodule

module register_file_scoreboard #(
    parameter  int DEPTH    = 32,
    parameter  int BITS     = 64,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   address1,
    input  logic [AW-1:0]   address2,
    output logic [BITS-1:0] read1,
    output logic [BITS-1:0] read2,
    input  logic [AW-1:0]   addressw,
    input  logic [BITS-1:0] writeData,
    input  logic            writeEn,
    input  logic            busySetEn,
    input  logic [AW-1:0]   busySetAddr,
    output logic            busy1,
    output logic            busy2,
    output logic [CW-1:0]   pendingCount
);
    logic [DEPTH-1:0][BITS-1:0] regs;
    logic [DEPTH-1:0]           busy;
    logic [DEPTH-1:0]           busy_nxt;
    logic [CW-1:0]              busy_cnt;
    logic                       wr_ok;
    logic                       set_ok;
    logic                       fwd_en;
    logic [1:0][AW-1:0]         raddr;
    logic [1:0][BITS-1:0]       rdata;
    logic [1:0]                 rbusy;

    assign wr_ok  = writeEn   && !((ZERO_REG != 0) && (addressw == '0));
    assign set_ok = busySetEn && !((ZERO_REG != 0) && (busySetAddr == '0));
    assign fwd_en = (BYPASS != 0) && writeEn && !rst;

    // Clear before set: a new producer issued in the writeback cycle keeps the reg busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok)
            busy_nxt[addressw] = 1'b0;
        if (set_ok)
            busy_nxt[busySetAddr] = 1'b1;
        if (rst)
            busy_nxt = '0;
    end

    // Count is taken from the next-state vector so it tracks busy in the same cycle.
    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < DEPTH; i++)
            busy_cnt = busy_cnt + CW'(busy_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            regs <= '0;
        else if (wr_ok)
            regs[addressw] <= writeData;
        busy         <= busy_nxt;
        pendingCount <= busy_cnt;
    end

    assign raddr = {address2, address1};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        register_file_scoreboard_rdport #(
            .DEPTH    (DEPTH),
            .BITS     (BITS),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .addr      (raddr[p]),
            .regs      (regs),
            .busy      (busy),
            .fwd_en    (fwd_en),
            .addressw  (addressw),
            .writeData (writeData),
            .rdata     (rdata[p]),
            .rbusy     (rbusy[p])
        );
    end

    assign read1 = rdata[0];
    assign read2 = rdata[1];
    assign busy1 = rbusy[0];
    assign busy2 = rbusy[1];
endmodule

// File: tb/tb_register_file_scoreboard.sv
// Bench for register_file_scoreboard: default config (zero reg + bypass) alongside a
// plain config (no zero reg, no bypass), both compared against an array-based model.

module tb_register_file_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  address1, address2, addressw, busySetAddr;
    logic [63:0] writeData;
    logic        writeEn, busySetEn;
    logic [63:0] rd1 [2];
    logic [63:0] rd2 [2];
    logic        bz1 [2];
    logic        bz2 [2];
    logic [5:0]  pc  [2];

    logic [63:0] m_reg  [2][32];
    bit          m_busy [2][32];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    register_file_scoreboard #(.DEPTH(32), .BITS(64), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .address1(address1), .address2(address2),
        .read1(rd1[0]), .read2(rd2[0]), .addressw(addressw), .writeData(writeData),
        .writeEn(writeEn), .busySetEn(busySetEn), .busySetAddr(busySetAddr),
        .busy1(bz1[0]), .busy2(bz2[0]), .pendingCount(pc[0])
    );

    register_file_scoreboard #(.DEPTH(32), .BITS(64), .ZERO_REG(0), .BYPASS(0)) u_alt (
        .clk(clk), .rst(rst), .address1(address1), .address2(address2),
        .read1(rd1[1]), .read2(rd2[1]), .addressw(addressw), .writeData(writeData),
        .writeEn(writeEn), .busySetEn(busySetEn), .busySetAddr(busySetAddr),
        .busy1(bz1[1]), .busy2(bz2[1]), .pendingCount(pc[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Instance 0 has the zero register and bypass, instance 1 has neither.
    function automatic logic [63:0] exp_read(int k, logic [4:0] a);
        if (k == 0 && a == 0) return 64'd0;
        if (k == 0 && writeEn && !rst && a == addressw) return writeData;
        return m_reg[k][a];
    endfunction

    function automatic logic [63:0] exp_busy(int k, logic [4:0] a);
        if (k == 0 && a == 0) return 64'd0;
        if (k == 0 && writeEn && !rst && a == addressw) return 64'd0;
        return {63'd0, m_busy[k][a]};
    endfunction

    function automatic logic [63:0] exp_count(int k);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[k][i]);
        return 64'(n);
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_reg[k][i]  = 64'd0;
                    m_busy[k][i] = 1'b0;
                end
            end else begin
                if (writeEn && !(k == 0 && addressw == 0)) begin
                    m_reg[k][addressw]  = writeData;
                    m_busy[k][addressw] = 1'b0;
                end
                if (busySetEn && !(k == 0 && busySetAddr == 0))
                    m_busy[k][busySetAddr] = 1'b1;
            end
        end
    endtask

    // Check combinational outputs mid-cycle, then advance model and DUT by one edge.
    task automatic cycle(input string tag);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s[%0d]/read1", tag, k), rd1[k], exp_read(k, address1));
            chk($sformatf("%s[%0d]/read2", tag, k), rd2[k], exp_read(k, address2));
            chk($sformatf("%s[%0d]/busy1", tag, k), {63'd0, bz1[k]}, exp_busy(k, address1));
            chk($sformatf("%s[%0d]/busy2", tag, k), {63'd0, bz2[k]}, exp_busy(k, address2));
            chk($sformatf("%s[%0d]/pending", tag, k), {58'd0, pc[k]}, exp_count(k));
        end
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        writeEn = 1'b0; busySetEn = 1'b0; rst = 1'b0;
    endtask

    task automatic rnd_inputs(input bit allow_rst);
        addressw    = 5'($urandom);
        writeData   = {$urandom, $urandom};
        writeEn     = ($urandom_range(0, 2) != 0);
        busySetEn   = ($urandom_range(0, 1) != 0);
        busySetAddr = ($urandom_range(0, 3) == 0) ? addressw : 5'($urandom);
        address1    = ($urandom_range(0, 3) == 0) ? addressw : 5'($urandom_range(0, 15));
        address2    = ($urandom_range(0, 3) == 0) ? busySetAddr : 5'($urandom);
        rst         = allow_rst && ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) begin
                m_reg[k][i]  = 64'd0;
                m_busy[k][i] = 1'b0;
            end
        address1 = 0; address2 = 0; addressw = 0; busySetAddr = 0;
        writeData = 0; writeEn = 0; busySetEn = 0; rst = 1'b1;
        @(posedge clk); #1;
        cycle("reset");
        rst = 1'b0;

        // random writes, then a single reset cycle clears everything
        for (int i = 0; i < 20; i++) begin
            rnd_inputs(1'b0);
            cycle("prefill");
        end
        idle(); rst = 1'b1;
        cycle("rst_mid");
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            address1 = 5'(i); address2 = 5'(i + 16);
            cycle("sweep");
        end

        // write-to-read bypass on r5 with a nonzero old value
        writeEn = 1'b1; addressw = 5; writeData = 64'h1111;
        cycle("r5_old");
        writeData = 64'hDEAD_BEEF; address1 = 5; address2 = 5;
        cycle("r5_bypass");
        idle();
        cycle("r5_after");

        // r0 write and busy-set
        writeEn = 1'b1; addressw = 0; writeData = 64'h1234;
        busySetEn = 1'b1; busySetAddr = 0; address1 = 0; address2 = 0;
        cycle("r0_wr");
        idle();
        cycle("r0_after");

        // busy r7 lifecycle
        busySetEn = 1'b1; busySetAddr = 7; address1 = 7; address2 = 3;
        cycle("r7_set");
        idle();
        cycle("r7_n1");
        cycle("r7_n2");
        writeEn = 1'b1; addressw = 7; writeData = 64'hA5A5_0007;
        cycle("r7_wb");
        idle();
        cycle("r7_n4");

        // set and clear r9 in the same cycle: set wins
        busySetEn = 1'b1; busySetAddr = 9; writeEn = 1'b1; addressw = 9;
        writeData = 64'h9999; address1 = 9; address2 = 9;
        cycle("r9_both");
        idle();
        cycle("r9_after");

        // fill scoreboard, reset midway, then fill to the top
        for (int i = 1; i < 32; i++) begin
            busySetEn = 1'b1; busySetAddr = 5'(i); address1 = 5'(i); address2 = 5'(i - 1);
            rst = (i == 20);
            cycle("fill_rst");
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            busySetEn = 1'b1; busySetAddr = 5'(i); address1 = 5'(i); address2 = 0;
            cycle("fill_all");
        end
        idle();
        busySetEn = 1'b1; busySetAddr = 4;
        cycle("set_again");
        idle();
        cycle("full");

        for (int i = 0; i < 300; i++) begin
            rnd_inputs(1'b1);
            cycle("random");
        end
        idle();
        cycle("final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
